// File: rtl/stream_packer.sv
// stream_packer
//   Width upsizer: gathers RATIO input beats of IN_W bits into one
//   OUT_W = IN_W*RATIO word. The word is presented on a ready/valid port,
//   together with a lane count and a last flag. When last_i arrives early,
//   the word is closed with only some lanes filled, and the unused lanes
//   read as zero. Under continuous downstream readiness the block accepts
//   one beat per cycle.
//
//   Optional feature macro: STREAM_PACKER_STRB_EN (adds strb_o).
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (has priority over all inputs)
//   clr_i    : synchronous clear, same effect as rst_i
//   valid_i  : input beat valid
//   ready_o  : input beat ready
//   data_i   : input beat payload [IN_W]
//   last_i   : closes the current word after this beat
//   valid_o  : output word valid
//   ready_i  : downstream ready
//   data_o   : packed word [OUT_W]; beat k occupies bits [k*IN_W +: IN_W]
//   last_o   : word was closed by last_i
//   count_o  : number of valid lanes, 1..RATIO (0 after reset)
//   strb_o   : (STREAM_PACKER_STRB_EN only) per-lane valid mask [RATIO]
module stream_packer #(
  parameter  int IN_W  = 8,
  parameter  int RATIO = 4,
  localparam int OUT_W = IN_W * RATIO,
  localparam int CNT_W = $clog2(RATIO + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic             last_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic             last_o,
  output logic [CNT_W-1:0] count_o
`ifdef STREAM_PACKER_STRB_EN
  ,
  output logic [RATIO-1:0] strb_o
`endif
);

  localparam int IDX_W = $clog2(RATIO);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] count_reg;
  logic             last_reg;
  logic [IN_W-1:0]  lane_reg [RATIO];

  logic             clear;
  logic             close_word;

  assign clear = rst_i | clr_i;

  // In FILL, the word closes on its final lane or on an early last_i.
  assign close_word = (idx_reg == IDX_W'(RATIO - 1)) | last_i;

  // In HOLD, a new beat is accepted only in the cycle that the held word
  // leaves. That cycle is when the lanes become free to reuse.
  assign ready_o = ~clear & ((state_reg == FILL) | ready_i);
  assign valid_o = (state_reg == HOLD);
  assign count_o = count_reg;
  assign last_o  = last_reg;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane_out
    assign data_o[gi*IN_W +: IN_W] = lane_reg[gi];
`ifdef STREAM_PACKER_STRB_EN
    // Lane gi holds a received beat iff fewer than count lanes precede it,
    // which is the same as (1<<count)-1.
    assign strb_o[gi] = (count_reg > CNT_W'(gi));
`endif
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state_reg <= FILL;
      idx_reg   <= '0;
      count_reg <= '0;
      last_reg  <= 1'b0;
      for (int i = 0; i < RATIO; i++) lane_reg[i] <= '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (valid_i) begin
            lane_reg[idx_reg] <= data_i;
            if (close_word) begin
              state_reg <= HOLD;
              count_reg <= CNT_W'(idx_reg) + CNT_W'(1);
              last_reg  <= last_i;
              idx_reg   <= '0;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (ready_i) begin
            // When the word is consumed, the lanes are wiped so that a
            // later partial word cannot show stale data.
            for (int i = 0; i < RATIO; i++) begin
              lane_reg[i] <= (i == 0 && valid_i) ? data_i : '0;
            end
            if (valid_i && last_i) begin
              // A one-beat word that closes at once goes straight back to HOLD.
              state_reg <= HOLD;
              count_reg <= CNT_W'(1);
              last_reg  <= 1'b1;
              idx_reg   <= '0;
            end else begin
              state_reg <= FILL;
              count_reg <= '0;
              last_reg  <= 1'b0;
              idx_reg   <= valid_i ? IDX_W'(1) : '0;
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Directed testbench for stream_packer with IN_W=8 and RATIO=4.
module tb_stream_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(RATIO + 1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             clr_i;
  logic             valid_i;
  logic             ready_o;
  logic [IN_W-1:0]  data_i;
  logic             last_i;
  logic             valid_o;
  logic             ready_i;
  logic [OUT_W-1:0] data_o;
  logic             last_o;
  logic [CNT_W-1:0] count_o;
`ifdef STREAM_PACKER_STRB_EN
  logic [RATIO-1:0] strb_o;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk_i = ~clk_i;

  stream_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .last_i  (last_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .last_o  (last_o),
    .count_o (count_o)
`ifdef STREAM_PACKER_STRB_EN
    ,
    .strb_o  (strb_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Moves 1 time unit past the next rising edge so that registered outputs
  // have settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    #1;
    chk("ready_beat", 64'(ready_o), 64'd1);
    tick();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input int cnt,
                          input logic l, input logic [3:0] s);
    chk({tag, "_valid"}, 64'(valid_o), 64'd1);
    chk({tag, "_data"},  64'(data_o),  64'(d));
    chk({tag, "_count"}, 64'(count_o), 64'(cnt));
    chk({tag, "_last"},  64'(last_o),  64'(l));
`ifdef STREAM_PACKER_STRB_EN
    chk({tag, "_strb"},  64'(strb_o),  64'(s));
`else
    if (s === 4'bxxxx) $display("unreachable");
`endif
  endtask

  task automatic consume();
    ready_i = 1'b1;
    valid_i = 1'b0;
    tick();
    chk("consume_valid", 64'(valid_o), 64'd0);
    chk("consume_data",  64'(data_o),  64'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] w;
    rst_i = 1'b1; clr_i = 1'b0; valid_i = 1'b0; data_i = '0; last_i = 1'b0; ready_i = 1'b0;
    tick();
    tick();
    chk("rst_ready",  64'(ready_o), 64'd0);
    chk("rst_valid",  64'(valid_o), 64'd0);
    chk("rst_data",   64'(data_o),  64'd0);
    chk("rst_count",  64'(count_o), 64'd0);
    chk("rst_last",   64'(last_o),  64'd0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(ready_o), 64'd1);

    // Full word of 4 beats.
    ready_i = 1'b1;
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    chk("lat_valid0", 64'(valid_o), 64'd0);
    beat(8'h44, 1'b0);
    chk_word("full", 32'h44332211, 4, 1'b0, 4'b1111);
    consume();

    // Early termination after 2 beats.
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b1);
    chk_word("part", 32'h0000BBAA, 2, 1'b1, 4'b0011);
    // The next full word starts while the partial word is being consumed.
    beat(8'h01, 1'b0);
    chk("part_gone", 64'(valid_o), 64'd0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b0);
    chk_word("nostale", 32'h04030201, 4, 1'b0, 4'b1111);
    consume();

    // Back-pressure.
    ready_i = 1'b0;
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b0);
    held = 32'h44332211;
    valid_i = 1'b1; data_i = 8'h55;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 64'(ready_o), 64'd0);
      tick();
      chk("bp_valid", 64'(valid_o), 64'd1);
      chk("bp_data",  64'(data_o),  64'(held));
      chk("bp_count", 64'(count_o), 64'd4);
    end
    ready_i = 1'b1;
    #1;
    chk("bp_release", 64'(ready_o), 64'd1);
    tick();
    valid_i = 1'b0;
    chk("bp_cons_valid", 64'(valid_o), 64'd0);
    chk("bp_lane0",      64'(data_o),  64'h55);
    beat(8'h66, 1'b0);
    beat(8'h77, 1'b0);
    beat(8'h88, 1'b0);
    chk_word("bp_next", 32'h88776655, 4, 1'b0, 4'b1111);

    // Sixteen beats back to back: 4 words with no input bubbles.
    for (int k = 0; k < 16; k++) begin
      beat(8'(8'hA0 + k), 1'b0);
      chk("strm_valid", 64'(valid_o), 64'((k % 4) == 3));
      if ((k % 4) == 3) begin
        w = {8'(8'hA0 + k), 8'(8'hA0 + k - 1), 8'(8'hA0 + k - 2), 8'(8'hA0 + k - 3)};
        chk("strm_data", 64'(data_o), 64'(w));
      end
    end
    consume();

    // Single beat closed by last_i.
    beat(8'h7E, 1'b1);
    chk_word("single", 32'h0000007E, 1, 1'b1, 4'b0001);
    // A single-beat word that closes in the consuming cycle stays in HOLD.
    beat(8'h9C, 1'b1);
    chk_word("hold_last", 32'h0000009C, 1, 1'b1, 4'b0001);
    consume();

    // Clear in the middle of a word.
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    clr_i = 1'b1; valid_i = 1'b1; data_i = 8'h03;
    #1;
    chk("clr_ready", 64'(ready_o), 64'd0);
    tick();
    clr_i = 1'b0; valid_i = 1'b0;
    chk("clr_valid", 64'(valid_o), 64'd0);
    chk("clr_data",  64'(data_o),  64'd0);
    chk("clr_count", 64'(count_o), 64'd0);
    beat(8'h10, 1'b0);
    beat(8'h20, 1'b0);
    beat(8'h30, 1'b0);
    beat(8'h40, 1'b0);
    chk_word("after_clr", 32'h40302010, 4, 1'b0, 4'b1111);

    // Reset while a word is being held.
    ready_i = 1'b0;
    tick();
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("rst2_ready", 64'(ready_o), 64'd0);
    tick();
    chk("rst2_valid", 64'(valid_o), 64'd0);
    chk("rst2_data",  64'(data_o),  64'd0);
    chk("rst2_count", 64'(count_o), 64'd0);
    chk("rst2_rdy_in", 64'(ready_o), 64'd0);
    rst_i = 1'b0;
    #1;
    chk("rst2_rdy_out", 64'(ready_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
